// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory stream loader.
// Define IMEM_LOADER_CHECKSUM_EN to add the trailing XOR checksum byte (CSUM state).
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int HEADER_BYTES   = 2;
    localparam int LEN_BITS       = 8 * HEADER_BYTES;

    typedef enum logic [2:0] {
        IDLE,
        LEN0,
        LEN1,
        DATA,
        WRITE,
`ifdef IMEM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE
    } loader_state_t;

    // States in which the loader takes a byte from the source.
    function automatic logic accepts_byte(input loader_state_t s);
        case (s)
            LEN0, LEN1, DATA: return 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            CSUM:             return 1'b1;
`endif
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/word_packer.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in [7:0].
// The full word is presented combinationally alongside the 4th byte.
module word_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_data,
    output logic [31:0] assembled,
    output logic        word_full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD);

    logic [23:0]      shreg;
    logic [CNT_W-1:0] byte_cnt;

    // Only the three most recent bytes are stored; the fourth completes the word in flight.
    assign assembled = {byte_data, shreg};
    assign word_full = shift_en && (byte_cnt == CNT_W'(BYTES_PER_WORD - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (clear) begin
            shreg    <= '0;
            byte_cnt <= '0;
        end else if (shift_en) begin
            shreg    <= assembled[31:8];
            byte_cnt <= byte_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction memory as 32-bit word writes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    output logic        wr_en,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [10:0] word_count
);

    loader_state_t       state;
    logic [7:0]          len_lo;
    logic [LEN_BITS-1:0] n_words;
    logic [LEN_BITS-1:0] hdr_len;
    logic                xfer;
    logic                pack_clear;
    logic                pack_shift;
    logic [31:0]         assembled;
    logic                word_full;
    logic                last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]          csum;
`endif

    assign byte_ready = accepts_byte(state);
    assign xfer       = byte_valid && byte_ready;
    assign pack_clear = (state == IDLE) && start;
    assign pack_shift = (state == DATA) && xfer;
    assign hdr_len    = {byte_data, len_lo};
    // word_count has already been bumped when this is consulted in WRITE.
    assign last_word  = (LEN_BITS'(word_count) == n_words);

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (pack_clear),
        .shift_en  (pack_shift),
        .byte_data (byte_data),
        .assembled (assembled),
        .word_full (word_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_lo     <= '0;
            n_words    <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LEN0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        error      <= 1'b0;
                        word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum       <= '0;
`endif
                    end
                end

                LEN0: begin
                    if (xfer) begin
                        len_lo <= byte_data;
                        state  <= LEN1;
                    end
                end

                LEN1: begin
                    if (xfer) begin
                        n_words <= hdr_len;
                        if (32'(hdr_len) > MEM_DEPTH) begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else if (hdr_len == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            state <= CSUM;
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
`endif
                        end else begin
                            state <= DATA;
                        end
                    end
                end

                // Outputs for the WRITE cycle are loaded on the way in so they are registered.
                DATA: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ byte_data;
`endif
                        if (word_full) begin
                            wr_en      <= 1'b1;
                            wr_addr    <= 32'({word_count, 2'b00});
                            wr_data    <= assembled;
                            word_count <= word_count + 1'b1;
                            state      <= WRITE;
                        end
                    end
                end

                WRITE: begin
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= CSUM;
`else
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
`endif
                    end else begin
                        state <= DATA;
                    end
                end

`ifdef IMEM_LOADER_CHECKSUM_EN
                CSUM: begin
                    if (xfer) begin
                        if (byte_data != csum) begin
                            error <= 1'b1;
                        end
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
`endif

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
